// File: rtl/apple2_slot_host.sv
// Apple II slot bus initiator: PHI1 phase, card reset and single bus cycles.
// Requests are accepted through req/ack and answered with a rsp_valid pulse.
module apple2_slot_host #(
    parameter int SLOT       = 7,
    parameter int RES_CYCLES = 4,
    parameter bit LONG_CYCLE = 1'b1
) (
    input  logic        C7M,
    input  logic        RES,
    output logic        PHI1,
    output logic        nRES,
    output logic [15:0] A,
    output logic        nWE,
    output logic [7:0]  D_o,
    output logic        D_oe,
    input  logic [7:0]  D_i,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ack,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata
);

    localparam logic [11:0] DEV_HI   = 12'hC08 + 12'(SLOT);
    localparam logic [7:0]  IO_HI    = 8'hC0 + 8'(SLOT);
    localparam logic [3:0]  RES_LAST = 4'(RES_CYCLES - 1);

    logic [2:0]  p_q, p_d, last_c;
    logic [6:0]  cc_q;
    logic [3:0]  rcnt_q;
    logic        nres_q;
    logic        end_c, accept_c;
    logic        dev_c, io_c, strb_c;

    logic        pend_q, pend_we_q;
    logic [15:0] pend_addr_q;
    logic [7:0]  pend_wdata_q;
    logic        tx_q, tx_we_q;
    logic [7:0]  tx_wdata_q;

    logic        phi1_q, nwe_q, doe_q, ack_q, rv_q;
    logic        ndev_q, nio_q, nstrb_q;
    logic [15:0] a_q;
    logic [7:0]  do_q, rd_q;

    // Phase sequencing, accept window and select decode of the bus address
    always_comb begin
        last_c   = (LONG_CYCLE && cc_q == 7'd64) ? 3'd7 : 3'd6;
        end_c    = (p_q == last_c);
        p_d      = end_c ? 3'd0 : p_q + 3'd1;
        accept_c = (p_q == last_c - 3'd1) && req && nres_q;
        dev_c    = (a_q[15:4] == DEV_HI);
        io_c     = (a_q[15:8] == IO_HI);
        strb_c   = (a_q[15:11] == 5'b11001);
    end

    // Bus cycle sequencer with registered bus outputs
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            p_q          <= 3'd0;
            cc_q         <= 7'd0;
            rcnt_q       <= 4'd0;
            nres_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= 16'h0000;
            pend_wdata_q <= 8'h00;
            tx_q         <= 1'b0;
            tx_we_q      <= 1'b0;
            tx_wdata_q   <= 8'h00;
            phi1_q       <= 1'b1;
            a_q          <= 16'h0000;
            nwe_q        <= 1'b1;
            do_q         <= 8'h00;
            doe_q        <= 1'b0;
            ndev_q       <= 1'b1;
            nio_q        <= 1'b1;
            nstrb_q      <= 1'b1;
            ack_q        <= 1'b0;
            rv_q         <= 1'b0;
            rd_q         <= 8'h00;
        end else begin
            p_q    <= p_d;
            phi1_q <= (p_d < 3'd3);
            ack_q  <= accept_c;
            if (accept_c) begin
                pend_q       <= 1'b1;
                pend_we_q    <= req_we;
                pend_addr_q  <= req_addr;
                pend_wdata_q <= req_wdata;
            end
            if (end_c) begin
                cc_q <= (cc_q == 7'd64) ? 7'd0 : cc_q + 7'd1;
                if (!nres_q) begin
                    if (rcnt_q == RES_LAST)
                        nres_q <= 1'b1;
                    else
                        rcnt_q <= rcnt_q + 4'd1;
                end
                rv_q <= tx_q;
                if (tx_q)
                    rd_q <= tx_we_q ? 8'h00 : D_i;
                tx_q       <= pend_q;
                tx_we_q    <= pend_we_q;
                tx_wdata_q <= pend_wdata_q;
                pend_q     <= 1'b0;
                if (pend_q)
                    a_q <= pend_addr_q;
                nwe_q   <= !(pend_q && pend_we_q);
                ndev_q  <= 1'b1;
                nio_q   <= 1'b1;
                nstrb_q <= 1'b1;
                doe_q   <= 1'b0;
            end else begin
                rv_q <= 1'b0;
                if (p_q == 3'd2 && tx_q) begin
                    ndev_q  <= !dev_c;
                    nio_q   <= !io_c;
                    nstrb_q <= !strb_c;
                end
                if (p_q == 3'd3 && tx_q && tx_we_q) begin
                    doe_q <= 1'b1;
                    do_q  <= tx_wdata_q;
                end
            end
        end
    end

    assign PHI1      = phi1_q;
    assign nRES      = nres_q;
    assign A         = a_q;
    assign nWE       = nwe_q;
    assign D_o       = do_q;
    assign D_oe      = doe_q;
    assign nDEVSEL   = ndev_q;
    assign nIOSEL    = nio_q;
    assign nIOSTRB   = nstrb_q;
    assign req_ack   = ack_q;
    assign rsp_valid = rv_q;
    assign rsp_rdata = rd_q;

endmodule

// File: tb/tb_apple2_slot_host.sv
// Randomized bench for apple2_slot_host against a cycle-timeline model.
// Bus cycles are located by arithmetic on clock count since reset release.
module tb_apple2_slot_host;

    localparam int SLOT       = 7;
    localparam int RES_CYCLES = 4;
    localparam bit LONG_CYCLE = 1'b1;

    logic        C7M = 1'b0;
    logic        RES = 1'b1;
    logic        PHI1, nRES, nWE, D_oe;
    logic [15:0] A;
    logic [7:0]  D_o, D_i;
    logic        nDEVSEL, nIOSEL, nIOSTRB;
    logic        req, req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ack, rsp_valid;
    logic [7:0]  rsp_rdata;

    apple2_slot_host #(
        .SLOT(SLOT), .RES_CYCLES(RES_CYCLES), .LONG_CYCLE(LONG_CYCLE)
    ) dut (
        .C7M(C7M), .RES(RES), .PHI1(PHI1), .nRES(nRES), .A(A), .nWE(nWE),
        .D_o(D_o), .D_oe(D_oe), .D_i(D_i), .nDEVSEL(nDEVSEL),
        .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 C7M = ~C7M;

    int vecs = 0;
    int errs = 0;

    // model state
    int          t, cyc_n, cyc_start, cyc_len, p;
    bit          req_cur, rq_we, force_wr;
    logic [15:0] rq_addr;
    logic [7:0]  rq_wdata, di_cur;
    bit          txv, tx_we;
    logic [15:0] tx_addr, expA;
    logic [7:0]  tx_wdata, exp_rdata;
    bit          exp_rsp;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
        end
    endtask

    function automatic int clen(input int n);
        return (LONG_CYCLE && (n % 65) == 64) ? 8 : 7;
    endfunction

    function automatic bit in_rng(input logic [15:0] a, input int lo,
                                  input int hi);
        return (int'(a) >= lo) && (int'(a) <= hi);
    endfunction

    task automatic model_reset();
        t = 0; cyc_n = 0; cyc_start = 0; cyc_len = clen(0); p = 0;
        req_cur = 0; txv = 0; tx_we = 0; tx_addr = 0; tx_wdata = 0;
        expA = 0; exp_rdata = 0; exp_rsp = 0;
    endtask

    task automatic advance();
        bit boundary;
        boundary = 0;
        if (t >= cyc_start + cyc_len) begin
            cyc_start += cyc_len;
            cyc_n++;
            cyc_len = clen(cyc_n);
            boundary = 1;
        end
        p = t - cyc_start;
        if (boundary) begin
            exp_rsp = txv;
            if (txv)
                exp_rdata = tx_we ? 8'h00 : di_cur;
            txv = 0;
            if (req_cur && (cyc_n - 1) >= RES_CYCLES) begin
                txv = 1; tx_we = rq_we; tx_addr = rq_addr;
                tx_wdata = rq_wdata; expA = rq_addr; req_cur = 0;
            end
        end else begin
            exp_rsp = 0;
        end
    endtask

    task automatic drive();
        logic [15:0] lst [10];
        lst = '{16'hC0F3, 16'hC0F0, 16'hC0F1, 16'hC700, 16'hC7FF,
                16'hCFFF, 16'hC800, 16'hC0E0, 16'hC600, 16'h0000};
        if (!req_cur) begin
            if (force_wr) begin
                req_cur = 1; rq_we = 1; rq_addr = 16'hC0F3;
                rq_wdata = 8'h5A; force_wr = 0;
            end else begin
                int k;
                req_cur = (cyc_n < RES_CYCLES) ? 1'b1
                        : ($urandom_range(0, 9) < 7);
                rq_we = $urandom_range(0, 1);
                k = $urandom_range(0, 12);
                rq_addr = (k < 10) ? lst[k] : 16'($urandom);
                rq_wdata = 8'($urandom);
            end
        end
        di_cur = 8'($urandom);
        req = req_cur; req_we = rq_we; req_addr = rq_addr;
        req_wdata = rq_wdata; D_i = di_cur;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".PHI1"}, PHI1, 1);
        chk({tag, ".nRES"}, nRES, 0);
        chk({tag, ".A"}, A, 0);
        chk({tag, ".nWE"}, nWE, 1);
        chk({tag, ".sel"}, {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        chk({tag, ".D_o"}, D_o, 0);
        chk({tag, ".D_oe"}, D_oe, 0);
        chk({tag, ".ack"}, req_ack, 0);
        chk({tag, ".rsp"}, rsp_valid, 0);
        chk({tag, ".rdata"}, rsp_rdata, 0);
    endtask

    task automatic check_run();
        bit sel, dev, io, strb, oe;
        sel  = txv && p >= 3;
        dev  = sel && in_rng(tx_addr, 'hC080 + 16 * SLOT, 'hC08F + 16 * SLOT);
        io   = sel && in_rng(tx_addr, 'hC000 + 256 * SLOT, 'hC0FF + 256 * SLOT);
        strb = sel && in_rng(tx_addr, 'hC800, 'hCFFF);
        oe   = txv && tx_we && p >= 4;
        chk("PHI1", PHI1, p < 3);
        chk("nRES", nRES, cyc_n >= RES_CYCLES);
        chk("A", A, expA);
        chk("nWE", nWE, !(txv && tx_we));
        chk("nDEVSEL", nDEVSEL, !dev);
        chk("nIOSEL", nIOSEL, !io);
        chk("nIOSTRB", nIOSTRB, !strb);
        chk("D_oe", D_oe, oe);
        if (oe)
            chk("D_o", D_o, tx_wdata);
        chk("req_ack", req_ack,
            req_cur && cyc_n >= RES_CYCLES && p == cyc_len - 1);
        chk("rsp_valid", rsp_valid, exp_rsp);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
    endtask

    task automatic step();
        @(posedge C7M);
        t++;
        advance();
        @(negedge C7M);
        check_run();
        if (p == 0)
            drive();
    endtask

    initial begin
        bit hit;
        force_wr = 0;
        req = 1; req_we = 0; req_addr = 16'hC0F0; req_wdata = 0; D_i = 0;
        model_reset();
        repeat (3) begin
            @(negedge C7M);
            chk_reset("por");
        end
        RES = 0;
        model_reset();
        drive();
        while (cyc_n < 140)
            step();

        force_wr = 1;
        hit = 0;
        for (int g = 0; g < 300 && !hit; g++) begin
            step();
            hit = txv && tx_we && tx_addr == 16'hC0F3 && p == 4;
        end
        chk("res_mid_reached", hit, 1);
        RES = 1;
        #1 chk_reset("res_mid");
        repeat (2) begin
            @(negedge C7M);
            chk_reset("res_hold");
        end
        RES = 0;
        model_reset();
        drive();
        while (cyc_n < 80)
            step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
